// File: rtl/config_pkg.sv
// Shared types for runtime extension reconfiguration: extension indices, status codes,
// build-time capability set, derived-configuration bundle and legalization helpers.
package config_pkg;

  localparam int unsigned EXT_W = 12;

  typedef enum logic [3:0] {
    EXT_F       = 4'd0,
    EXT_D       = 4'd1,
    EXT_XF16    = 4'd2,
    EXT_XF16ALT = 4'd3,
    EXT_XF8     = 4'd4,
    EXT_XFVEC   = 4'd5,
    EXT_A       = 4'd6,
    EXT_B       = 4'd7,
    EXT_C       = 4'd8,
    EXT_V       = 4'd9,
    EXT_H       = 4'd10,
    EXT_ZICOND  = 4'd11
  } ext_idx_e;

  typedef enum logic [1:0] {
    CFG_OK        = 2'd0,
    CFG_LEGALIZED = 2'd1,
    CFG_TIMEOUT   = 2'd2,
    CFG_NOCHANGE  = 2'd3
  } cfg_status_e;

  typedef struct packed {
    logic CvxifEn;
    logic RVZiCond;
    logic RVH;
    logic RVV;
    logic RVC;
    logic RVB;
    logic RVA;
    logic XFVec;
    logic XF8;
    logic XF16ALT;
    logic XF16;
    logic RVD;
    logic RVF;
  } cva6_cfg_t;

  typedef struct packed {
    logic       fp_present;
    logic       nsx;
    logic [6:0] flen;
    logic [3:0] fpvec;
    logic [2:0] nr_wb_ports;
  } cfg_drv_t;

  function automatic logic [EXT_W-1:0] cap_mask(cva6_cfg_t c);
    cap_mask = {c.RVZiCond, c.RVH, c.RVV, c.RVC, c.RVB, c.RVA,
                c.XFVec, c.XF8, c.XF16ALT, c.XF16, c.RVD, c.RVF};
  endfunction

  // Order matters: D depends on F, and XFVec depends on whatever FP formats survive.
  function automatic logic [EXT_W-1:0] legalize_ext(logic [EXT_W-1:0] raw, logic [EXT_W-1:0] cap);
    logic [EXT_W-1:0] m;
    m = raw & cap;
    if (!m[EXT_F]) m[EXT_D] = 1'b0;
    if (!(m[EXT_F] | m[EXT_D] | m[EXT_XF16] | m[EXT_XF16ALT] | m[EXT_XF8])) m[EXT_XFVEC] = 1'b0;
    legalize_ext = m;
  endfunction

endpackage

// File: rtl/runtime_cfg_derive.sv
// Combinational legalization of an extension vector and derivation of FP/writeback parameters.
// Zero latency, no flow control.
module runtime_cfg_derive
  import config_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_t'{default:0}
) (
  input  logic [EXT_W-1:0] ext_i,
  output logic [EXT_W-1:0] ext_o,
  output cfg_drv_t         drv_o
);

  logic [EXT_W-1:0] m;
  logic [6:0]       flen;

  always_comb begin
    m = legalize_ext(ext_i, cap_mask(CVA6Cfg));

    if (m[EXT_D])                          flen = 7'd64;
    else if (m[EXT_F])                     flen = 7'd32;
    else if (m[EXT_XF16] | m[EXT_XF16ALT]) flen = 7'd16;
    else if (m[EXT_XF8])                   flen = 7'd8;
    else                                   flen = 7'd1;

    drv_o             = '0;
    drv_o.fp_present  = m[EXT_F] | m[EXT_D] | m[EXT_XF16] | m[EXT_XF16ALT] | m[EXT_XF8];
    drv_o.nsx         = m[EXT_XF16] | m[EXT_XF16ALT] | m[EXT_XF8] | m[EXT_XFVEC];
    drv_o.flen        = flen;
    // A vector format needs at least two elements packed in one FP register.
    drv_o.fpvec[0]    = m[EXT_F]       & m[EXT_XFVEC] & (flen > 7'd32);
    drv_o.fpvec[1]    = m[EXT_XF16]    & m[EXT_XFVEC] & (flen > 7'd16);
    drv_o.fpvec[2]    = m[EXT_XF16ALT] & m[EXT_XFVEC] & (flen > 7'd16);
    drv_o.fpvec[3]    = m[EXT_XF8]     & m[EXT_XFVEC] & (flen > 7'd8);
    drv_o.nr_wb_ports = (CVA6Cfg.CvxifEn || m[EXT_V]) ? 3'd5 : 3'd4;
  end

  assign ext_o = m;

endmodule

// File: rtl/runtime_cfg_ctrl.sv
// Runtime extension-enable controller: legalize request, drain pipeline, apply, respond.
// NOCHANGE answers 1 cycle after accept; changes land 2 cycles after flush ack; response held until consumed.
module runtime_cfg_ctrl
  import config_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_t'{default:0},
  parameter int unsigned           DrainTimeout = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [EXT_W-1:0] req_ext_i,
  output logic             flush_req_o,
  input  logic             flush_ack_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [1:0]       resp_status_o,
  output logic [EXT_W-1:0] ext_en_o,
  output logic             fp_present_o,
  output logic             nsx_o,
  output logic [6:0]       flen_o,
  output logic [3:0]       fpvec_o,
  output logic [2:0]       nr_wb_ports_o,
  output logic             busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int unsigned     CW       = $clog2(DrainTimeout) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DrainTimeout - 1);
  localparam logic [EXT_W-1:0] RST_EXT = legalize_ext(cap_mask(CVA6Cfg), cap_mask(CVA6Cfg));

  logic [1:0]       state_q, state_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic [EXT_W-1:0] pend_q, pend_d;
  logic             leg_q, leg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  cfg_status_e      status_q, status_d;

  logic [EXT_W-1:0] req_legal;
  logic [EXT_W-1:0] act_ext_unused;
  cfg_drv_t         req_drv_unused;
  cfg_drv_t         act_drv;

  runtime_cfg_derive #(.CVA6Cfg(CVA6Cfg)) u_req_derive (
    .ext_i (req_ext_i),
    .ext_o (req_legal),
    .drv_o (req_drv_unused)
  );

  runtime_cfg_derive #(.CVA6Cfg(CVA6Cfg)) u_act_derive (
    .ext_i (ext_q),
    .ext_o (act_ext_unused),
    .drv_o (act_drv)
  );

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    pend_d   = pend_q;
    leg_d    = leg_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          pend_d = req_legal;
          leg_d  = (req_legal != req_ext_i);
          cnt_d  = '0;
          if (req_legal == ext_q) begin
            state_d  = ST_RESP;
            status_d = CFG_NOCHANGE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (flush_ack_i) begin
          state_d = ST_APPLY;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_RESP;
          status_d = CFG_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_APPLY: begin
        ext_d    = pend_q;
        status_d = leg_q ? CFG_LEGALIZED : CFG_OK;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      ext_q    <= RST_EXT;
      pend_q   <= '0;
      leg_q    <= 1'b0;
      cnt_q    <= '0;
      status_q <= CFG_OK;
    end else begin
      state_q  <= state_d;
      ext_q    <= ext_d;
      pend_q   <= pend_d;
      leg_q    <= leg_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign flush_req_o   = (state_q == ST_DRAIN);
  assign resp_valid_o  = (state_q == ST_RESP);
  assign busy_o        = (state_q != ST_IDLE);
  assign resp_status_o = status_q;
  assign ext_en_o      = ext_q;
  assign fp_present_o  = act_drv.fp_present;
  assign nsx_o         = act_drv.nsx;
  assign flen_o        = act_drv.flen;
  assign fpvec_o       = act_drv.fpvec;
  assign nr_wb_ports_o = act_drv.nr_wb_ports;

endmodule

// File: tb/tb_runtime_cfg_ctrl.sv
// Directed bench: instance A has full capability with a short drain timeout,
// instance B lacks D and CV-X-IF.
module tb_runtime_cfg_ctrl;
  import config_pkg::*;

  localparam cva6_cfg_t CFG_A = cva6_cfg_t'('1);
  localparam cva6_cfg_t CFG_B = '{RVD: 1'b0, CvxifEn: 1'b0, default: 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic             a_req_valid, a_req_ready, a_flush_req, a_flush_ack, a_resp_valid, a_resp_ready;
  logic             a_fp, a_nsx, a_busy;
  logic [EXT_W-1:0] a_req_ext, a_ext;
  logic [1:0]       a_status;
  logic [6:0]       a_flen;
  logic [3:0]       a_fpvec;
  logic [2:0]       a_nrwb;

  logic             b_req_valid, b_req_ready, b_flush_req, b_flush_ack, b_resp_valid, b_resp_ready;
  logic             b_fp, b_nsx, b_busy;
  logic [EXT_W-1:0] b_req_ext, b_ext;
  logic [1:0]       b_status;
  logic [6:0]       b_flen;
  logic [3:0]       b_fpvec;
  logic [2:0]       b_nrwb;

  runtime_cfg_ctrl #(.CVA6Cfg(CFG_A), .DrainTimeout(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_ext_i(a_req_ext),
    .flush_req_o(a_flush_req), .flush_ack_i(a_flush_ack),
    .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready), .resp_status_o(a_status),
    .ext_en_o(a_ext), .fp_present_o(a_fp), .nsx_o(a_nsx), .flen_o(a_flen),
    .fpvec_o(a_fpvec), .nr_wb_ports_o(a_nrwb), .busy_o(a_busy)
  );

  runtime_cfg_ctrl #(.CVA6Cfg(CFG_B), .DrainTimeout(16)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_ext_i(b_req_ext),
    .flush_req_o(b_flush_req), .flush_ack_i(b_flush_ack),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready), .resp_status_o(b_status),
    .ext_en_o(b_ext), .fp_present_o(b_fp), .nsx_o(b_nsx), .flen_o(b_flen),
    .fpvec_o(b_fpvec), .nr_wb_ports_o(b_nrwb), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_accept(input logic [EXT_W-1:0] ext);
    a_req_valid = 1'b1;
    a_req_ext   = ext;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic a_consume();
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_ext = '0; a_flush_ack = 1'b0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_ext = '0; b_flush_ack = 1'b0; b_resp_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_a_ready",  a_req_ready, 1);
    chk("rst_a_ext",    a_ext, 12'hFFF);
    chk("rst_a_status", a_status, 0);
    chk("rst_a_busy",   a_busy, 0);
    chk("rst_a_flush",  a_flush_req, 0);
    chk("rst_a_rvld",   a_resp_valid, 0);
    chk("rst_a_flen",   a_flen, 64);
    chk("rst_a_fpvec",  a_fpvec, 4'hF);
    chk("rst_a_nrwb",   a_nrwb, 5);
    chk("rst_b_ext",    b_ext, 12'hFFD);
    chk("rst_b_flen",   b_flen, 32);
    chk("rst_b_fpvec",  b_fpvec, 4'hE);
    chk("rst_b_nrwb",   b_nrwb, 5);
    rst_n = 1'b1;
    tick();

    // F only, ack in third drain cycle
    a_accept(12'h001);
    chk("f_flush",  a_flush_req, 1);
    chk("f_busy",   a_busy, 1);
    chk("f_ready",  a_req_ready, 0);
    tick();
    tick();
    a_flush_ack = 1'b1;
    tick();
    a_flush_ack = 1'b0;
    chk("f_apply_rvld", a_resp_valid, 0);
    chk("f_apply_ext",  a_ext, 12'hFFF);
    tick();
    chk("f_rvld",   a_resp_valid, 1);
    chk("f_ext",    a_ext, 12'h001);
    chk("f_flen",   a_flen, 32);
    chk("f_fp",     a_fp, 1);
    chk("f_nsx",    a_nsx, 0);
    chk("f_status", a_status, CFG_OK);
    chk("f_nrwb",   a_nrwb, 5);
    a_consume();
    chk("f_idle_ready", a_req_ready, 1);
    chk("f_idle_busy",  a_busy, 0);

    // Stray ack while idle
    a_flush_ack = 1'b1;
    tick();
    a_flush_ack = 1'b0;
    chk("stray_busy", a_busy, 0);
    chk("stray_ext",  a_ext, 12'h001);

    // Request equal to current enables
    a_accept(12'h001);
    chk("nc_rvld",   a_resp_valid, 1);
    chk("nc_status", a_status, CFG_NOCHANGE);
    chk("nc_flush",  a_flush_req, 0);
    a_consume();

    // F, D, XFVec then stalled response
    a_accept(12'h023);
    a_flush_ack = 1'b1;
    tick();
    a_flush_ack = 1'b0;
    tick();
    chk("fdv_ext",    a_ext, 12'h023);
    chk("fdv_flen",   a_flen, 64);
    chk("fdv_fpvec",  a_fpvec, 4'b0001);
    chk("fdv_nsx",    a_nsx, 1);
    chk("fdv_status", a_status, CFG_OK);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rvld",   a_resp_valid, 1);
      chk("stall_status", a_status, CFG_OK);
      chk("stall_ext",    a_ext, 12'h023);
    end
    a_consume();

    // D without F legalizes to nothing; ack on the last drain cycle beats timeout
    a_accept(12'h002);
    tick();
    tick();
    tick();
    a_flush_ack = 1'b1;
    tick();
    a_flush_ack = 1'b0;
    chk("aw_flush", a_flush_req, 0);
    chk("aw_rvld",  a_resp_valid, 0);
    tick();
    chk("aw_rvld2",  a_resp_valid, 1);
    chk("aw_status", a_status, CFG_LEGALIZED);
    chk("aw_ext",    a_ext, 12'h000);
    chk("aw_flen",   a_flen, 1);
    chk("aw_fp",     a_fp, 0);
    a_consume();

    // Drain timeout
    a_accept(12'h001);
    for (int i = 0; i < 4; i++) begin
      chk("to_flush", a_flush_req, 1);
      tick();
    end
    chk("to_flush_end", a_flush_req, 0);
    chk("to_rvld",      a_resp_valid, 1);
    chk("to_status",    a_status, CFG_TIMEOUT);
    chk("to_ext",       a_ext, 12'h000);
    a_consume();

    // Capability without D
    b_req_valid = 1'b1;
    b_req_ext   = 12'h003;
    tick();
    b_req_valid = 1'b0;
    b_flush_ack = 1'b1;
    tick();
    b_flush_ack = 1'b0;
    tick();
    chk("nod_rvld",   b_resp_valid, 1);
    chk("nod_ext",    b_ext, 12'h001);
    chk("nod_status", b_status, CFG_LEGALIZED);
    chk("nod_flen",   b_flen, 32);
    chk("nod_nrwb",   b_nrwb, 4);
    b_resp_ready = 1'b1;
    tick();
    b_resp_ready = 1'b0;

    // Reset mid-drain
    a_accept(12'h001);
    tick();
    chk("md_flush", a_flush_req, 1);
    rst_n = 1'b0;
    #1;
    chk("md_flush_rst", a_flush_req, 0);
    chk("md_busy",      a_busy, 0);
    chk("md_ext",       a_ext, 12'hFFF);
    chk("md_ready",     a_req_ready, 1);
    chk("md_rvld",      a_resp_valid, 0);
    chk("md_status",    a_status, CFG_OK);
    rst_n = 1'b1;
    tick();
    chk("md_post_busy", a_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
